sfx_mixer: RTL and testbench

- Parametrised successor to the single-track background tone generator.
- Plays up to NUM_VOICES independent sound clips (background loop plus one-shot game effects) out of one shared sample ROM.
- Each voice has its own start address, length, loop mode and 4-bit volume. Voices are serviced in turn once per sample tick, scaled, summed, saturated, and presented to the audio codec channels with a ready/valid handshake.

---
 rtl/sfx_mixer.sv | 203 ++++++++++++++++++++
 tb/tb_sfx_mixer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_mixer.sv
// sfx_mixer: multi-voice sample mixer that reads one shared synchronous sample ROM.
// Once per sample tick every voice is fetched in turn, scaled by its 4-bit
// volume, summed, saturated, and offered to the codec with valid/ready.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   trigger, stop         per-voice 1-cycle start/restart and silence pulses
//   start_addr, clip_len  per-voice clip address/length, voice i at [i*ADDR_W +: ADDR_W]
//   loop_mode, volume     per-voice wrap enable and 0..15 gain (volume packed 4 bits/voice)
//   rom_addr, rom_data    shared ROM port (data one cycle after address)
//   left/right_chan_ready codec readies; the sample is accepted when both are high
//   sample_data/valid     mixed sample, held until accepted
//   voice_active          per-voice playing flag
//   overrun_count         saturating count of frames dropped while a sample was held
//
// Optional build macro: SFX_DUCK_EN halves voice 0 while any other voice plays.
`timescale 1ns/1ps
module sfx_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int ADDR_W     = 17,
  parameter int CLK_DIV    = 6250
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_VOICES-1:0]      trigger,
  input  logic [NUM_VOICES-1:0]      stop,
  input  logic [NUM_VOICES*ADDR_W-1:0] start_addr,
  input  logic [NUM_VOICES*ADDR_W-1:0] clip_len,
  input  logic [NUM_VOICES-1:0]      loop_mode,
  input  logic [NUM_VOICES*4-1:0]    volume,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [SAMPLE_W-1:0]        rom_data,
  input  logic                       left_chan_ready,
  input  logic                       right_chan_ready,
  output logic [SAMPLE_W-1:0]        sample_data,
  output logic                       sample_valid,
  output logic [NUM_VOICES-1:0]      voice_active,
  output logic [7:0]                 overrun_count
);

  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int PROD_W = SAMPLE_W + 5;

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(1 << (SAMPLE_W - 1)));

  typedef enum logic [1:0] {IDLE, FETCH, MIX, OUT} state_t;
  state_t state, state_next;

  logic [CNT_W-1:0]      tick_cnt;
  logic                  tick;
  logic                  apply;
  logic                  accept;

  logic [ADDR_W-1:0]     v_start [NUM_VOICES];
  logic [ADDR_W-1:0]     v_len   [NUM_VOICES];
  logic [ADDR_W-1:0]     v_off   [NUM_VOICES];
  logic [3:0]            v_vol   [NUM_VOICES];
  logic [NUM_VOICES-1:0] v_loop;
  logic [NUM_VOICES-1:0] active;

  logic [NUM_VOICES-1:0] pend_trig, pend_stop;
  logic [NUM_VOICES-1:0] eff_trig, eff_stop;

  logic [IDX_W-1:0]      fetch_idx;
  logic [IDX_W-1:0]      mix_idx;
  logic                  mix_en;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W-1:0]  contrib;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  mix_sum;
  logic [SAMPLE_W-1:0]      sat_sample;

  assign tick   = (tick_cnt == CNT_W'(CLK_DIV - 1));
  assign apply  = (state == IDLE) && tick;
  assign accept = sample_valid && left_chan_ready && right_chan_ready;

  // Pulses arriving on the applying cycle itself are honoured immediately.
  assign eff_trig = pend_trig | trigger;
  assign eff_stop = pend_stop | stop;

  assign voice_active = active;

  // Next-state and ROM address
  always_comb begin
    state_next = state;
    rom_addr   = '0;
    case (state)
      IDLE:  if (tick) state_next = FETCH;
      FETCH: begin
        if (active[fetch_idx]) rom_addr = v_start[fetch_idx] + v_off[fetch_idx];
        if (fetch_idx == IDX_W'(NUM_VOICES - 1)) state_next = MIX;
      end
      MIX:   state_next = OUT;
      OUT:   if (accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef SFX_DUCK_EN
  logic others_active;
  always_comb begin
    others_active = 1'b0;
    for (int unsigned i = 1; i < NUM_VOICES; i++) others_active = others_active | active[i];
  end
`endif

  // Scale the sample that returned for mix_idx; ROM data lags fetch by one cycle.
  always_comb begin
    prod = PROD_W'($signed(rom_data)) * PROD_W'($signed({1'b0, v_vol[mix_idx]}));
`ifdef SFX_DUCK_EN
    if (mix_idx == '0 && others_active) shifted = ACC_W'(prod >>> 5);
    else                                shifted = ACC_W'(prod >>> 4);
`else
    shifted = ACC_W'(prod >>> 4);
`endif
    contrib = (mix_en && active[mix_idx]) ? shifted : '0;
    mix_sum = acc + contrib;
    if (mix_sum > ACC_MAX)      sat_sample = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (mix_sum < ACC_MIN) sat_sample = {1'b1, {(SAMPLE_W-1){1'b0}}};
    else                        sat_sample = mix_sum[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      fetch_idx     <= '0;
      mix_idx       <= '0;
      mix_en        <= 1'b0;
      acc           <= '0;
      pend_trig     <= '0;
      pend_stop     <= '0;
      sample_data   <= '0;
      sample_valid  <= 1'b0;
      overrun_count <= '0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      pend_trig <= apply ? '0 : eff_trig;
      pend_stop <= apply ? '0 : eff_stop;
      mix_en    <= (state == FETCH);
      mix_idx   <= fetch_idx;
      fetch_idx <= (state == FETCH) ? fetch_idx + 1'b1 : '0;

      if (apply)       acc <= '0;
      else if (mix_en) acc <= mix_sum;

      // MIX carries the last voice's addition, so the sum is saturated straight from mix_sum.
      if (state == MIX) begin
        sample_data  <= sat_sample;
        sample_valid <= 1'b1;
      end else if (accept) begin
        sample_valid <= 1'b0;
      end

      if (state == OUT && tick && overrun_count != '1)
        overrun_count <= overrun_count + 1'b1;
    end
  end

  // Per-voice state: commands only at the frame boundary, advance on the voice's mix cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        v_start[i] <= '0;
        v_len[i]   <= '0;
        v_off[i]   <= '0;
        v_vol[i]   <= '0;
      end
      v_loop <= '0;
      active <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (apply) begin
          if (eff_stop[i]) begin
            active[i] <= 1'b0;
          end else if (eff_trig[i] && clip_len[i*ADDR_W +: ADDR_W] != '0) begin
            v_start[i] <= start_addr[i*ADDR_W +: ADDR_W];
            v_len[i]   <= clip_len[i*ADDR_W +: ADDR_W];
            v_vol[i]   <= volume[i*4 +: 4];
            v_loop[i]  <= loop_mode[i];
            v_off[i]   <= '0;
            active[i]  <= 1'b1;
          end
        end else if (mix_en && mix_idx == IDX_W'(i) && active[i]) begin
          if (v_off[i] == v_len[i] - 1'b1) begin
            if (v_loop[i]) v_off[i]  <= '0;
            else           active[i] <= 1'b0;
          end else begin
            v_off[i] <= v_off[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sfx_mixer.sv
// tb_sfx_mixer: directed and randomized bench for sfx_mixer (CLK_DIV = 16).
// A frame-level reference model applies queued trigger/stop commands at each
// frame, mixes the active clips from a bench-owned ROM image, and advances
// clip offsets; each accepted sample is compared against it.
`timescale 1ns/1ps
module tb_sfx_mixer;
  localparam int NV = 4;
  localparam int SW = 16;
  localparam int AW = 17;
  localparam int CD = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NV-1:0]   trigger, stop, loop_mode, voice_active;
  logic [NV*AW-1:0] start_addr, clip_len;
  logic [NV*4-1:0] volume;
  logic [AW-1:0]   rom_addr;
  logic [SW-1:0]   rom_data, sample_data;
  logic            left_chan_ready, right_chan_ready, sample_valid;
  logic [7:0]      overrun_count;

  sfx_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .ADDR_W(AW), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .stop(stop),
    .start_addr(start_addr), .clip_len(clip_len), .loop_mode(loop_mode), .volume(volume),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .left_chan_ready(left_chan_ready), .right_chan_ready(right_chan_ready),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .voice_active(voice_active), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  // ROM image, aliased on the low 8 address bits
  logic [SW-1:0] mem [256];
  always @(posedge clk) rom_data <= mem[rom_addr[7:0]];

  logic [AW-1:0] b_start [NV];
  logic [AW-1:0] b_len   [NV];
  logic [3:0]    b_vol   [NV];
  logic [NV-1:0] b_loop;

  always_comb begin
    start_addr = '0;
    clip_len   = '0;
    volume     = '0;
    for (int i = 0; i < NV; i++) begin
      start_addr[i*AW +: AW] = b_start[i];
      clip_len[i*AW +: AW]   = b_len[i];
      volume[i*4 +: 4]       = b_vol[i];
    end
  end
  assign loop_mode = b_loop;

  // Reference model state
  int            m_start [NV];
  int            m_len   [NV];
  int            m_off   [NV];
  int            m_vol   [NV];
  logic [NV-1:0] m_loop, m_act, m_ptrig, m_pstop;
  int            m_ovr;

  int errors = 0;
  int checks = 0;
  int last_wait = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = '0; m_loop = '0; m_ptrig = '0; m_pstop = '0; m_ovr = 0;
    for (int i = 0; i < NV; i++) begin
      m_start[i] = 0; m_len[i] = 0; m_off[i] = 0; m_vol[i] = 0;
    end
  endtask

  task automatic model_frame(output logic [15:0] exp);
    int sum, c, a;
`ifdef SFX_DUCK_EN
    logic others;
`endif
    for (int i = 0; i < NV; i++) begin
      if (m_pstop[i]) m_act[i] = 1'b0;
      else if (m_ptrig[i] && b_len[i] != 0) begin
        m_start[i] = int'(b_start[i]);
        m_len[i]   = int'(b_len[i]);
        m_vol[i]   = int'(b_vol[i]);
        m_loop[i]  = b_loop[i];
        m_off[i]   = 0;
        m_act[i]   = 1'b1;
      end
    end
    m_ptrig = '0;
    m_pstop = '0;
`ifdef SFX_DUCK_EN
    others = |m_act[NV-1:1];
`endif
    sum = 0;
    for (int i = 0; i < NV; i++) begin
      if (m_act[i]) begin
        a = (m_start[i] + m_off[i]) % (1 << AW);
        c = int'($signed(mem[a % 256])) * m_vol[i];
        c = c >>> 4;
`ifdef SFX_DUCK_EN
        if (i == 0 && others) c = c >>> 1;
`endif
        sum += c;
        if (m_off[i] == m_len[i] - 1) begin
          if (m_loop[i]) m_off[i] = 0;
          else           m_act[i] = 1'b0;
        end else begin
          m_off[i]++;
        end
      end
    end
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
    exp = sum[15:0];
  endtask

  task automatic wait_valid(input string tag);
    int w;
    w = 0;
    while (sample_valid !== 1'b1 && w < 4*CD) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    check({tag, "_valid"}, {31'd0, sample_valid}, 32'd1);
  endtask

  // Expects both readies high; leaves the bench on the IDLE cycle after acceptance.
  task automatic do_frame(input string tag, input int fixed);
    logic [15:0] exp;
    wait_valid(tag);
    model_frame(exp);
    check({tag, "_data"}, sample_data, exp);
    if (fixed >= 0) check({tag, "_const"}, sample_data, fixed[15:0]);
    check({tag, "_active"}, voice_active, m_act);
    check({tag, "_ovr"}, overrun_count, m_ovr);
    check({tag, "_addr_out"}, rom_addr, 0);
    @(negedge clk);
    check({tag, "_valid_drop"}, sample_valid, 0);
  endtask

  task automatic pulse(input logic [NV-1:0] t, input logic [NV-1:0] s);
    trigger = t;
    stop    = s;
    m_ptrig |= t;
    m_pstop |= s;
    @(negedge clk);
    trigger = '0;
    stop    = '0;
  endtask

  task automatic set_voice(input int i, input int st, input int len, input int vol, input logic lp);
    b_start[i] = AW'(st);
    b_len[i]   = AW'(len);
    b_vol[i]   = 4'(vol);
    b_loop[i]  = lp;
  endtask

  initial begin
    logic [15:0] exp;
    logic [NV-1:0] t, s;
    reset = 1'b0;
    trigger = '0;
    stop = '0;
    left_chan_ready = 1'b1;
    right_chan_ready = 1'b1;
    b_loop = '0;
    for (int i = 0; i < NV; i++) set_voice(i, 0, 0, 0, 1'b0);
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[100] = 16'h1000; mem[101] = 16'h2000; mem[102] = 16'h3000;
    mem[10]  = 16'h0100; mem[11]  = 16'h0200;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_active", voice_active, 0);
    check("rst_ovr", overrun_count, 0);
    reset = 1'b1;
    @(negedge clk);

    // Idle frames: silent, one per CLK_DIV cycles
    do_frame("idle0", 0);
    do_frame("idle1", 0);
    check("tick_period", last_wait + 1, CD);

    // One-shot clip
    set_voice(1, 100, 3, 15, 1'b0);
    pulse(4'b0010, 4'b0000);
    do_frame("oneshot0", 16'h0F00);
    do_frame("oneshot1", 16'h1E00);
    do_frame("oneshot2", 16'h2D00);
    do_frame("oneshot3", 0);

    // Looping clip, then restart mid-clip, then zero-length trigger ignored
    set_voice(0, 10, 2, 8, 1'b1);
    pulse(4'b0001, 4'b0000);
    do_frame("loop0", 16'h0080);
    do_frame("loop1", 16'h0100);
    do_frame("loop2", 16'h0080);
    pulse(4'b0001, 4'b0000);
    do_frame("retrig", 16'h0080);
    set_voice(2, 40, 0, 15, 1'b1);
    pulse(4'b0100, 4'b0000);
    do_frame("len0", 16'h0100);

    // Trigger and stop together: stop wins
    pulse(4'b0001, 4'b0001);
    do_frame("stopwins", 0);

    // Address wrap past the top of the ROM space
    set_voice(3, (1 << AW) - 1, 3, 15, 1'b0);
    pulse(4'b1000, 4'b0000);
    do_frame("wrap0", -1);
    do_frame("wrap1", -1);
    do_frame("wrap2", -1);

    // Saturation both ways
    mem[200] = 16'h7000;
    for (int i = 0; i < NV; i++) set_voice(i, 200, 1, 15, 1'b1);
    pulse(4'b1111, 4'b0000);
    do_frame("sat_pos", 16'h7FFF);
    mem[200] = 16'h9000;
    do_frame("sat_neg", 16'h8000);
    pulse(4'b0000, 4'b1111);
    do_frame("all_stop", 0);

    // Randomized commands
    for (int r = 0; r < 14; r++) begin
      t = NV'($urandom);
      s = ($urandom_range(0, 3) == 0) ? NV'($urandom) : '0;
      for (int i = 0; i < NV; i++)
        if (t[i])
          set_voice(i, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, (1 << AW) - 1)) : (1 << AW) - 2,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 15)), 1'($urandom));
      pulse(t, s);
      repeat ($urandom_range(1, 3)) do_frame("rand", -1);
    end

    // Backpressure: sample held, two frames dropped, voices frozen
    set_voice(0, 20, 3, 15, 1'b1);
    pulse(4'b0001, 4'b1110);
    do_frame("hs_pre", -1);
    right_chan_ready = 1'b0;
    wait_valid("hs_hold");
    model_frame(exp);
    check("hs_hold_data", sample_data, exp);
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      check("hs_stable_data", sample_data, exp);
      check("hs_stable_valid", sample_valid, 1);
    end
    m_ovr += 2;
    check("hs_ovr", overrun_count, m_ovr);
    right_chan_ready = 1'b1;
    @(negedge clk);
    check("hs_valid_drop", sample_valid, 0);
    do_frame("hs_post0", -1);
    do_frame("hs_post1", -1);

    // Ducking of voice 0 under an effect voice
    mem[60] = 16'h2000;
    mem[50] = 16'h0000;
    set_voice(0, 60, 1, 15, 1'b1);
    set_voice(1, 50, 1, 15, 1'b1);
    pulse(4'b0011, 4'b1100);
`ifdef SFX_DUCK_EN
    do_frame("duck_on", 16'h0F00);
`else
    do_frame("duck_on", 16'h1E00);
`endif
    pulse(4'b0000, 4'b0010);
    do_frame("duck_off", 16'h1E00);

    // Asynchronous reset in the middle of FETCH
    repeat (10) @(negedge clk);
    check("fetch_addr", rom_addr, (m_start[0] + m_off[0]) % (1 << AW));
    reset = 1'b0;
    #1;
    check("arst_valid", sample_valid, 0);
    check("arst_data", sample_data, 0);
    check("arst_addr", rom_addr, 0);
    check("arst_active", voice_active, 0);
    check("arst_ovr", overrun_count, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    do_frame("post_reset", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
